// File: rtl/light_timer.sv
// Light timer: second prescaler plus per-light seconds countdown.
// Produces the last-second and prescaler pre-wrap strobes for the light FSM.
module light_timer #(
  parameter int LIGHT_STATE_WIDTH = 3,
  parameter int CLK_PER_SEC       = 4,
  parameter int CNT_WIDTH         = 8,
  parameter int GREEN_SEC         = 5,
  parameter int YELLOW_SEC        = 2,
  parameter int RED_SEC           = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
  output logic                         light_cnt_last,
  output logic                         second_cnt_pre_last,
  output logic [CNT_WIDTH-1:0]         remaining_sec
);

  localparam int SW = $clog2(CLK_PER_SEC);
  localparam logic [SW-1:0] SEC_LAST = SW'(CLK_PER_SEC - 1);
  localparam logic [SW-1:0] SEC_PRE  = SW'(CLK_PER_SEC - 2);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [SW-1:0]                sec_cnt;
  logic [CNT_WIDTH-1:0]         light_cnt;
  logic [LIGHT_STATE_WIDTH-1:0] init_q;
  logic [CNT_WIDTH-1:0]         dur;
  logic                         idle;
  logic                         change;
  logic                         wrap;

  // Lowest set bit wins when the select is not one-hot.
  always_comb begin
    dur = '0;
    if (light_cnt_init[0]) begin
      dur = CNT_WIDTH'(GREEN_SEC);
    end else if (light_cnt_init[1]) begin
      dur = CNT_WIDTH'(YELLOW_SEC);
    end else if (light_cnt_init[2]) begin
      dur = CNT_WIDTH'(RED_SEC);
    end
  end

  assign idle   = (light_cnt_init == '0);
  assign change = (light_cnt_init != init_q);
  assign wrap   = (sec_cnt == SEC_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      sec_cnt   <= '0;
      light_cnt <= '0;
      init_q    <= '0;
    end else begin
      init_q <= light_cnt_init;
      if (idle) begin
        sec_cnt   <= '0;
        light_cnt <= '0;
      end else if (change) begin
        sec_cnt   <= '0;
        light_cnt <= dur;
      end else if (wrap) begin
        sec_cnt <= '0;
        // Reload instead of underflowing if the FSM fails to move on.
        if (light_cnt == ONE) begin
          light_cnt <= dur;
        end else begin
          light_cnt <= light_cnt - ONE;
        end
      end else begin
        sec_cnt <= sec_cnt + SW'(1);
      end
    end
  end

  assign second_cnt_pre_last = en & ~idle & (sec_cnt == SEC_PRE);
  assign light_cnt_last      = (light_cnt == ONE);
  assign remaining_sec       = light_cnt;

endmodule
